// File: rtl/ram_fill_checker.sv
// Memory-mapped RAM filler/checker: writes or verifies a pattern over a word range
// of an attached single-cycle-latency RAM, one word per cycle, with sticky status and irq.
module ram_fill_checker #(
    parameter int RAM_WORDS = 51200,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    output logic              irq
);

    // Interface timing: a CSR access is a single-cycle strobe qualified by
    // csr_chipselect; read data appears registered on the following cycle.
    // RAM address/strobes are registered, and ram_readdata for an address
    // presented in cycle k is valid (and compared) in cycle k+1.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    logic              ctrl_mode;
    logic              ctrl_irq_en;
    logic              ctrl_incr;
    logic              sts_done;
    logic              sts_error;
    logic [ADDR_W-1:0] base_q;
    logic [16:0]       length_q;
    logic [31:0]       pattern_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [16:0]       err_count_q;

    logic [16:0]       remain_q;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [31:0]       cmp_data;

    logic              busy;
    logic              csr_wr;
    logic              csr_rd;
    logic              start_req;
    logic              cfg_wr_ok;
    logic              done_clr;
    logic              last_word;
    logic              mismatch;
    logic              launch;
    logic              set_done;
    logic [31:0]       rd_mux;
    logic              unused_cfg;

    assign busy      = (state != IDLE);
    assign csr_wr    = csr_chipselect & csr_write;
    assign csr_rd    = csr_chipselect & csr_read;
    assign start_req = csr_wr & (csr_address == 3'd0) & csr_writedata[0];
    assign cfg_wr_ok = csr_wr & ~busy;
    assign done_clr  = csr_wr & (csr_address == 3'd1) & csr_writedata[1];
    assign last_word = (remain_q == 17'd0);
    assign mismatch  = cmp_valid & (ram_readdata != cmp_data);

    assign ram_byteenable = 4'hF;
    assign ram_clken      = 1'b1;
    assign irq            = sts_done & ctrl_irq_en;
    assign unused_cfg     = (RAM_WORDS == 0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MODE is taken from the START write itself so one CTRL write can both
    // configure and launch an operation.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        set_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (length_q == 17'd0) begin
                        set_done = 1'b1;
                    end else begin
                        launch     = 1'b1;
                        state_next = csr_writedata[1] ? CHECK : FILL;
                    end
                end
            end
            FILL: begin
                if (last_word) begin
                    state_next = IDLE;
                    set_done   = 1'b1;
                end
            end
            CHECK: begin
                if (last_word) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                set_done   = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_mode   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_incr   <= 1'b0;
            base_q      <= '0;
            length_q    <= '0;
            pattern_q   <= '0;
        end else if (cfg_wr_ok) begin
            case (csr_address)
                3'd0: begin
                    ctrl_mode   <= csr_writedata[1];
                    ctrl_irq_en <= csr_writedata[2];
                    ctrl_incr   <= csr_writedata[3];
                end
                3'd2: base_q    <= csr_writedata[ADDR_W-1:0];
                3'd3: length_q  <= csr_writedata[16:0];
                3'd4: pattern_q <= csr_writedata;
                default: begin
                end
            endcase
        end
    end

    // Status bits: a completion or mismatch in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sts_done    <= 1'b0;
            sts_error   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (set_done) begin
                sts_done <= 1'b1;
            end else if (done_clr) begin
                sts_done <= 1'b0;
            end

            if (launch) begin
                sts_error <= 1'b0;
            end else if (mismatch) begin
                sts_error <= 1'b1;
            end else if (done_clr) begin
                sts_error <= 1'b0;
            end

            if (launch) begin
                err_addr_q  <= '0;
                err_count_q <= '0;
            end else if (mismatch) begin
                if (err_count_q == 17'd0) begin
                    err_addr_q <= cmp_addr;
                end
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + 17'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM request datapath and compare pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_address    <= '0;
            ram_writedata  <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            remain_q       <= '0;
        end else if (launch) begin
            ram_address    <= base_q;
            ram_writedata  <= pattern_q;
            ram_chipselect <= 1'b1;
            ram_write      <= ~csr_writedata[1];
            remain_q       <= length_q - 17'd1;
        end else if ((state == FILL) || (state == CHECK)) begin
            if (last_word) begin
                ram_chipselect <= 1'b0;
                ram_write      <= 1'b0;
            end else begin
                ram_address   <= ram_address + ADDR_W'(1);
                ram_writedata <= ram_writedata + {31'd0, ctrl_incr};
                remain_q      <= remain_q - 17'd1;
            end
        end
    end

    // ram_writedata doubles as the expected word while checking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_data  <= '0;
        end else begin
            cmp_valid <= (state == CHECK);
            cmp_addr  <= ram_address;
            cmp_data  <= ram_writedata;
        end
    end

    // ------------------------------------------------------------------
    // CSR read-back
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (csr_address)
            3'd0: rd_mux[3:1]        = {ctrl_incr, ctrl_irq_en, ctrl_mode};
            3'd1: rd_mux[2:0]        = {sts_error, sts_done, busy};
            3'd2: rd_mux[ADDR_W-1:0] = base_q;
            3'd3: rd_mux[16:0]       = length_q;
            3'd4: rd_mux             = pattern_q;
            3'd5: rd_mux[ADDR_W-1:0] = err_addr_q;
            3'd6: rd_mux[16:0]       = err_count_q;
            default: rd_mux          = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_rd) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ram_fill_checker.sv
// Bench for ram_fill_checker: RAM model, CSR driver tasks, reference memory model,
// and a negedge monitor that pops expected CSR reads and RAM accesses from queues.
module tb_ram_fill_checker;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    csr_address;
    logic          csr_chipselect;
    logic          csr_write;
    logic          csr_read;
    logic [31:0]   csr_writedata;
    logic [31:0]   csr_readdata;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [31:0]   ram_writedata;
    logic          ram_clken;
    logic [31:0]   ram_readdata;
    logic          irq;

    always #5 clk = ~clk;

    ram_fill_checker #(.RAM_WORDS(51200), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (rst),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_read       (csr_read),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .irq            (irq)
    );

    // Synchronous RAM with one cycle of read latency
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) mem[ram_address] <= ram_writedata;
            ram_readdata <= mem[ram_address];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   data;
        logic          first;
    } ram_acc_t;

    logic [31:0]   exp_q[$];
    ram_acc_t      ram_exp_q[$];
    logic [31:0]   ref_mem [logic [AW-1:0]];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_acc = 0;
    bit            rd_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT activity at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops expectations whenever the DUT presents a response
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        ram_acc_t    e;
        logic [31:0] c;
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                flag("csr_unexpected_read");
            end else begin
                c = exp_q.pop_front();
                check("csr_readdata", csr_readdata, c);
            end
        end
        rd_pending = csr_chipselect && csr_read;
        if (ram_chipselect) begin
            if (ram_exp_q.size() == 0) begin
                flag("ram_unexpected_access");
            end else begin
                e = ram_exp_q.pop_front();
                check("ram_address", {16'd0, ram_address}, {16'd0, e.addr});
                check("ram_write", {31'd0, ram_write}, {31'd0, e.we});
                if (e.we) check("ram_writedata", ram_writedata, e.data);
                check("ram_byteenable", {28'd0, ram_byteenable}, 32'hF);
                if (!e.first) check("ram_gap", cyc - last_acc, 32'd1);
            end
            last_acc = cyc;
        end else begin
            check("ram_write_idle", {31'd0, ram_write}, 32'd0);
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        csr_address    = a;
        csr_writedata  = d;
        csr_chipselect = 1'b1;
        csr_write      = 1'b1;
        @(posedge clk);
        #1;
        csr_chipselect = 1'b0;
        csr_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        csr_address    = a;
        csr_chipselect = 1'b1;
        csr_read       = 1'b1;
        @(posedge clk);
        #1;
        csr_chipselect = 1'b0;
        csr_read       = 1'b0;
    endtask

    // Runs one operation; the reference model derives every RAM access and
    // the final status from base/length/pattern and the reference memory.
    task automatic run_op(input logic [15:0] base, input logic [16:0] len, input logic [31:0] pat,
                          input bit mode, input bit incr, input bit irq_en, input bit pokes);
        int            errs;
        int            errs_early;
        int            busy_cycles;
        logic [15:0]   first_addr;
        logic [15:0]   a;
        logic [31:0]   d;
        errs = 0;
        errs_early = 0;
        first_addr = 16'h0;
        bus_write(3'd2, {16'd0, base});
        bus_write(3'd3, {15'd0, len});
        bus_write(3'd4, pat);
        bus_write(3'd1, 32'h2);
        for (int i = 0; i < int'(len); i++) begin
            a = base + 16'(i);
            d = pat + (incr ? 32'(i) : 32'd0);
            ram_exp_q.push_back('{addr: a, we: !mode, data: d, first: (i == 0)});
            if (!mode) begin
                ref_mem[a] = d;
            end else if (!ref_mem.exists(a) || ref_mem[a] !== d) begin
                if (errs == 0) first_addr = a;
                errs++;
                if (i < int'(len) - 1) errs_early++;
            end
        end
        bus_write(3'd0, {28'd0, incr, irq_en, mode, 1'b1});
        if (len == 17'd0) begin
            bus_read(3'd1, 32'h2);
            return;
        end
        busy_cycles = mode ? int'(len) + 1 : int'(len);
        if (pokes) begin
            bus_write(3'd0, 32'hF);
            bus_write(3'd4, ~pat);
            bus_write(3'd2, {16'd0, base + 16'd5});
        end
        repeat (busy_cycles - 1 - (pokes ? 3 : 0)) begin
            @(posedge clk);
            #1;
        end
        bus_read(3'd1, {29'd0, (errs_early > 0), 1'b0, 1'b1});
        bus_read(3'd1, {29'd0, (errs > 0), 1'b1, 1'b0});
        check("irq_on_done", {31'd0, irq}, {31'd0, irq_en});
        bus_read(3'd5, {16'd0, ((errs > 0) ? first_addr : 16'h0)});
        bus_read(3'd6, {15'd0, 17'(errs)});
        if (pokes) begin
            bus_read(3'd0, {28'd0, incr, irq_en, mode, 1'b0});
            bus_read(3'd2, {16'd0, base});
            bus_read(3'd4, pat);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] b;
        logic [16:0] l;
        logic [16:0] off;
        logic [16:0] sl;
        logic [31:0] p;
        logic [31:0] cp;
        bit          inc;

        rst            = 1'b1;
        csr_address    = 3'd0;
        csr_chipselect = 1'b0;
        csr_write      = 1'b0;
        csr_read       = 1'b0;
        csr_writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csr_readdata", csr_readdata, 32'd0);
        check("rst_ram_cs", {31'd0, ram_chipselect}, 32'd0);
        check("rst_ram_address", {16'd0, ram_address}, 32'd0);
        check("rst_ram_writedata", ram_writedata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) bus_read(3'(i), 32'd0);

        // Directed: fill, passing check, corrupted check, address wrap
        run_op(16'h0010, 17'd4, 32'hA5A50000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h0010, 17'd4, 32'hA5A50000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(16'h0012, 17'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0010, 17'd4, 32'hA5A50000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(16'hFFFE, 17'd3, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'hFFFE, 17'd3, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);

        // LENGTH=0 and writes/START while busy
        run_op(16'h0040, 17'd0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0100, 17'd8, 32'hCAFE0000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op(16'h0100, 17'd8, 32'hCAFE0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Interrupt set on completion, cleared by DONE write
        run_op(16'h0200, 17'd3, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_write(3'd1, 32'h2);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(3'd1, 32'd0);

        // Randomized fill then check of a sub-range, matching or not
        for (int n = 0; n < 10; n++) begin
            b   = 16'($urandom_range(0, 65535));
            l   = 17'($urandom_range(1, 40));
            p   = $urandom;
            inc = 1'($urandom_range(0, 1));
            run_op(b, l, p, 1'b0, inc, 1'b0, (l >= 17'd4) && ($urandom_range(0, 1) == 1));
            off = 17'($urandom_range(0, int'(l) - 1));
            sl  = 17'($urandom_range(1, int'(l - off)));
            if ($urandom_range(0, 1) == 1) cp = p + (inc ? 32'(off) : 32'd0);
            else cp = $urandom;
            run_op(b + off[15:0], sl, cp, 1'b1, inc, 1'b0, (sl >= 17'd3) && ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of a fill aborts it
        bus_write(3'd2, 32'h0300);
        bus_write(3'd3, 32'd20);
        bus_write(3'd4, 32'h77770000);
        bus_write(3'd1, 32'h2);
        for (int i = 0; i < 20; i++)
            ram_exp_q.push_back('{addr: 16'h0300 + 16'(i), we: 1'b1, data: 32'h77770000 + 32'(i), first: (i == 0)});
        bus_write(3'd0, 32'h9);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        ram_exp_q.delete();
        #1;
        check("abort_ram_cs", {31'd0, ram_chipselect}, 32'd0);
        check("abort_ram_write", {31'd0, ram_write}, 32'd0);
        check("abort_csr_readdata", csr_readdata, 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 7; i++) bus_read(3'(i), 32'd0);
        run_op(16'h0400, 17'd5, 32'h55AA55AA, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h0400, 17'd5, 32'h55AA55AA, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("csr_queue_empty", exp_q.size(), 32'd0);
        check("ram_queue_empty", ram_exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_fill_checker.md
RAM_FILL_CHECKER -- requirements
Module: ram_fill_checker

Interface
REQ-001 The block SHALL use the following parameters: RAM_WORDS, default 51200, number of addressable 32-bit words in the attached on-chip RAM; ADDR_W, default 16, RAM word-address width.
REQ-002 The block SHALL have the following ports (clock and reset first):
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- csr_address  in  3  CSR word select.
- csr_chipselect  in  1  CSR access qualifier.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, valid 1 cycle after the read.
- ram_address  out  ADDR_W  RAM word address.
- ram_byteenable  out  4  RAM byte enables.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  32  RAM write data.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  32  RAM read data; fixed 1-cycle latency after address.
- irq  out  1  level interrupt to the Nios II.
REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-high reset (reset).

Function
REQ-004 The CSR map SHALL be:
- 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 MODE (0 fill, 1 check), bit2 IRQ_EN, bit3 INCR.
- 1 STATUS: bit0 BUSY, bit1 DONE, bit2 ERROR; writing 1 to bit1 clears DONE and ERROR.
- 2 BASE[ADDR_W-1:0].
- 3 LENGTH[16:0], in words.
- 4 PATTERN[31:0].
- 5 ERR_ADDR[ADDR_W-1:0], first mismatch address.
- 6 ERR_COUNT[16:0].
- 7 reads 0.
REQ-005 csr_readdata SHALL be registered, updated on the cycle after csr_chipselect&csr_read, and unused bits SHALL read 0.
REQ-006 Writes to CTRL bits 1-3, BASE, LENGTH and PATTERN while BUSY SHALL be ignored.
REQ-007 The expected/write data for word i SHALL be PATTERN+i (mod 2^32) when INCR=1, else PATTERN; the address SHALL be BASE+i (mod 2^ADDR_W).
REQ-008 FSM states SHALL be IDLE, FILL, CHECK, DRAIN.
REQ-009 IDLE: START with LENGTH=0 SHALL set DONE without any RAM access; START with LENGTH>0 SHALL clear ERROR, ERR_ADDR and ERR_COUNT, set BUSY, and enter FILL (MODE=0) or CHECK (MODE=1) on the next cycle.
REQ-010 FILL SHALL assert ram_chipselect=1 and ram_write=1 with one word per cycle for LENGTH consecutive cycles, then return to IDLE, clear BUSY, and set DONE.
REQ-011 CHECK SHALL assert ram_chipselect=1 and ram_write=0, issue one address per cycle for LENGTH cycles, and compare ram_readdata against expected data one cycle later.
REQ-012 After the last address issues, CHECK SHALL go to DRAIN for one cycle to compare the final word, then return to IDLE with BUSY cleared and DONE set.
REQ-013 Each mismatch SHALL increment ERR_COUNT, saturating at 2^17-1; the first mismatch SHALL latch ERR_ADDR and set ERROR.
REQ-014 START while BUSY SHALL be ignored.
REQ-015 ram_byteenable SHALL be 4'hF and ram_clken SHALL be 1 at all times.
REQ-016 ram_chipselect and ram_write SHALL be 0 in IDLE.
REQ-017 The RAM outputs SHALL be registered.
REQ-018 irq SHALL equal DONE & IRQ_EN.
REQ-019 When a DONE set coincides with a DONE-clear write, the set SHALL win.
REQ-020 Throughput SHALL be one word per cycle with no bubbles; total busy time SHALL be LENGTH cycles (fill) or LENGTH+1 cycles (check).

Reset
REQ-021 Asserting reset SHALL, asynchronously:
- zero all CSRs, csr_readdata, ram_address, ram_writedata, ram_chipselect, ram_write and irq;
- set the FSM to IDLE.
REQ-022 Reset mid-operation SHALL abort with no further RAM access.
REQ-023 After reset, the block SHALL require a new START.

Verification
REQ-024 Fill: BASE=0x0010, LENGTH=4, PATTERN=0xA5A50000, INCR=1, START -> writes 0xA5A50000..0xA5A50003 to addresses 0x10..0x13 on 4 consecutive cycles; DONE=1.
REQ-025 Check pass: check the same region with a RAM model -> ERR_COUNT=0, ERROR=0, DONE after 5 busy cycles.
REQ-026 Check fail: corrupt address 0x12 -> ERROR=1, ERR_ADDR=0x12, ERR_COUNT=1.
REQ-027 Wrap: BASE=0xFFFE, LENGTH=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-028 Edge cases: LENGTH=0 START -> DONE next cycle, no ram_chipselect pulse; START while BUSY -> no effect.
REQ-029 IRQ_EN=1, completion -> irq=1; write STATUS=0x2 -> irq=0; assert reset mid-fill -> ram_chipselect=0 immediately, BUSY=0.
